// File: rtl/affine_mac_pipe.sv
// affine_mac_pipe: LANES-wide signed affine multiply/add with per-lane accumulators, 2-stage valid/ready pipeline.
// Optional build macro AFFINE_MAC_SAT_EN: saturate the scaled product and the lane add instead of wrapping.
module affine_mac_pipe #(
  parameter int unsigned W     = 8,
  parameter int unsigned LANES = 2,
  parameter int unsigned FRAC  = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] a,
  input  logic [LANES*W-1:0] c,
  input  logic [1:0]         mul_sel,
  input  logic [1:0]         add_sel,
  input  logic               frac_c,
  input  logic               acc_we,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] r,
  output logic               busy
);

  localparam int unsigned PW = 2 * W;

  typedef logic signed [W-1:0]  lane_t;
  typedef logic signed [PW-1:0] prod_t;

`ifdef AFFINE_MAC_SAT_EN
  localparam lane_t LANE_MAX = lane_t'({1'b0, {(W-1){1'b1}}});
  localparam lane_t LANE_MIN = lane_t'({1'b1, {(W-1){1'b0}}});
`endif

  // Select the W-bit window of the full product; arithmetic shift gives truncation toward -inf.
  function automatic lane_t scale_prod(input prod_t p, input logic frac);
    prod_t sh;
    lane_t res;
    sh  = frac ? (p >>> FRAC) : p;
    res = lane_t'(sh);
`ifdef AFFINE_MAC_SAT_EN
    if (sh != prod_t'(res)) res = sh[PW-1] ? LANE_MIN : LANE_MAX;
`endif
    return res;
  endfunction

  function automatic lane_t lane_add(input lane_t x, input lane_t y);
`ifdef AFFINE_MAC_SAT_EN
    logic signed [W:0] s;
    s = (W+1)'(x) + (W+1)'(y);
    if (s[W] != s[W-1]) return s[W] ? LANE_MIN : LANE_MAX;
    return lane_t'(s);
`else
    return x + y;
`endif
  endfunction

  logic       s1_valid_q, s1_valid_d;
  prod_t      s1_prod_q [LANES];
  prod_t      s1_prod_d [LANES];
  logic       s1_frac_q, s1_frac_d;
  logic [1:0] s1_add_sel_q, s1_add_sel_d;
  logic       s1_acc_we_q, s1_acc_we_d;
  logic       out_valid_q, out_valid_d;
  lane_t      r_q   [LANES];
  lane_t      r_d   [LANES];
  lane_t      acc_q [LANES];
  lane_t      acc_d [LANES];

  lane_t      mul_a  [LANES];
  prod_t      prod   [LANES];
  lane_t      ps     [LANES];
  lane_t      addend [LANES];
  lane_t      sum    [LANES];

  logic       advance;
  logic       accept;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || advance;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign busy      = s1_valid_q | out_valid_q;

  for (genvar g = 0; g < LANES; g++) begin : g_pack
    assign r[g*W +: W] = r_q[g];
  end

  // Stage 1 datapath: operand select and full-width signed product.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      mul_a[i] = '0;
      if (mul_sel[1])       mul_a[i] = lane_t'(1);
      else if (!mul_sel[0]) mul_a[i] = lane_t'(a[i*W +: W]);
      prod[i] = prod_t'(mul_a[i]) * prod_t'($signed(c[i*W +: W]));
    end
  end

  // Stage 2 datapath: scale, pick the addend (accumulator as it stands now, zero, or partner lane), add.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      ps[i] = scale_prod(s1_prod_q[i], s1_frac_q);
    end
    for (int i = 0; i < LANES; i++) begin
      addend[i] = '0;
      if (s1_add_sel_q[1])       addend[i] = ps[i ^ 1];
      else if (!s1_add_sel_q[0]) addend[i] = acc_q[i];
      sum[i] = lane_add(ps[i], addend[i]);
    end
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_prod_d    = s1_prod_q;
    s1_frac_d    = s1_frac_q;
    s1_add_sel_d = s1_add_sel_q;
    s1_acc_we_d  = s1_acc_we_q;
    out_valid_d  = out_valid_q;
    r_d          = r_q;
    acc_d        = acc_q;

    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_prod_d    = prod;
      s1_frac_d    = frac_c;
      s1_add_sel_d = add_sel;
      s1_acc_we_d  = acc_we;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    if (advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) r_d = sum;
    end

    // Clear has priority over a coincident writeback.
    if (acc_clr) begin
      for (int i = 0; i < LANES; i++) acc_d[i] = '0;
    end else if (advance && s1_valid_q && s1_acc_we_q) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_frac_q    <= 1'b0;
      s1_add_sel_q <= '0;
      s1_acc_we_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_prod_q[i] <= '0;
        r_q[i]       <= '0;
        acc_q[i]     <= '0;
      end
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_prod_q    <= s1_prod_d;
      s1_frac_q    <= s1_frac_d;
      s1_add_sel_q <= s1_add_sel_d;
      s1_acc_we_q  <= s1_acc_we_d;
      out_valid_q  <= out_valid_d;
      r_q          <= r_d;
      acc_q        <= acc_d;
    end
  end

endmodule

// File: tb/tb_affine_mac_pipe.sv
// tb_affine_mac_pipe: directed vector table plus handwritten accumulate, stall and reset sequences.
module tb_affine_mac_pipe;

  localparam int unsigned W     = 8;
  localparam int unsigned LANES = 2;
  localparam int unsigned FRAC  = 7;
  localparam int          NV    = 10;

`ifdef AFFINE_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] a;
  logic [LANES*W-1:0] c;
  logic [1:0]         mul_sel;
  logic [1:0]         add_sel;
  logic               frac_c;
  logic               acc_we;
  logic               acc_clr;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] r;
  logic               busy;

  affine_mac_pipe #(.W(W), .LANES(LANES), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .c         (c),
    .mul_sel   (mul_sel),
    .add_sel   (add_sel),
    .frac_c    (frac_c),
    .acc_we    (acc_we),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mul_sel;
    logic [1:0] add_sel;
    logic       frac;
    logic [7:0] a0;
    logic [7:0] c0;
    logic [7:0] a1;
    logic [7:0] c1;
    logic [7:0] r0;
    logic [7:0] r1;
  } vec_t;

  vec_t vecs [NV];

  int n_cmp = 0;
  int n_err = 0;
  int sent;
  int got;
  bit saw_stall;
  bit acc_b;
  bit take;
  bit stall;
  logic [LANES*W-1:0] prev_r;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //          mul    add    frac  a0     c0     a1     c1     r0                    r1
    vecs[0] = {2'b00, 2'b01, 1'b1, 8'h40, 8'h40, 8'h00, 8'h00, 8'h20,                8'h00};
    vecs[1] = {2'b00, 2'b10, 1'b0, 8'h02, 8'h03, 8'h04, 8'h05, 8'h1A,                8'h1A};
    vecs[2] = {2'b10, 2'b01, 1'b0, 8'h55, 8'h07, 8'h00, 8'hFD, 8'h07,                8'hFD};
    vecs[3] = {2'b00, 2'b01, 1'b0, 8'h7F, 8'h02, 8'h80, 8'h02, SAT ? 8'h7F : 8'hFE,  SAT ? 8'h80 : 8'h00};
    vecs[4] = {2'b01, 2'b01, 1'b1, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h00,                8'h00};
    vecs[5] = {2'b00, 2'b01, 1'b1, 8'hC0, 8'h40, 8'hFF, 8'h01, 8'hE0,                8'hFF};
    vecs[6] = {2'b00, 2'b01, 1'b1, 8'h80, 8'h80, 8'h7F, 8'h7F, SAT ? 8'h7F : 8'h80,  8'h7E};
    vecs[7] = {2'b00, 2'b11, 1'b0, 8'h64, 8'h01, 8'h64, 8'h01, SAT ? 8'h7F : 8'hC8,  SAT ? 8'h7F : 8'hC8};
    vecs[8] = {2'b00, 2'b10, 1'b0, 8'h9C, 8'h01, 8'h9C, 8'h01, SAT ? 8'h80 : 8'h38,  SAT ? 8'h80 : 8'h38};
    vecs[9] = {2'b11, 2'b01, 1'b1, 8'h00, 8'h7F, 8'h00, 8'h80, 8'h00,                8'hFF};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; c = '0;
    mul_sel = 2'b00; add_sel = 2'b01; frac_c = 1'b0; acc_we = 1'b0; acc_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_r",         r,              16'h0000);
    check("rst_busy",      16'(busy),      16'd0);
    check("rst_in_ready",  16'(in_ready),  16'd1);

    // Single-beat vectors: out_valid low one edge after acceptance, high after the second.
    for (int k = 0; k < NV; k++) begin
      mul_sel  = vecs[k].mul_sel;
      add_sel  = vecs[k].add_sel;
      frac_c   = vecs[k].frac;
      a        = {vecs[k].a1, vecs[k].a0};
      c        = {vecs[k].c1, vecs[k].c0};
      in_valid = 1'b1;
      #1;
      check($sformatf("v%0d_in_ready", k), 16'(in_ready), 16'd1);
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_lat1_valid", k), 16'(out_valid), 16'd0);
      tick();
      check($sformatf("v%0d_valid", k), 16'(out_valid), 16'd1);
      check($sformatf("v%0d_r0", k), 16'(r[7:0]),  16'(vecs[k].r0));
      check($sformatf("v%0d_r1", k), 16'(r[15:8]), 16'(vecs[k].r1));
      tick();
    end

    // Accumulate chain, then clear coinciding with the third writeback.
    mul_sel = 2'b00; add_sel = 2'b00; frac_c = 1'b0; acc_we = 1'b1;
    a = 16'h0002; c = 16'h0003; in_valid = 1'b1;
    tick();
    tick();
    check("acc_b1_valid", 16'(out_valid), 16'd1);
    check("acc_b1_r0", 16'(r[7:0]), 16'd6);
    tick();
    check("acc_b2_r0", 16'(r[7:0]), 16'd12);
    acc_clr = 1'b1; a = 16'h0001; c = 16'h0001;
    tick();
    check("acc_b3_r0", 16'(r[7:0]), 16'd18);
    acc_clr = 1'b0; in_valid = 1'b0;
    tick();
    check("acc_clr_b4_r0", 16'(r[7:0]), 16'd1);
    acc_we = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("acc_after_clr_r0", 16'(r[7:0]), 16'd2);
    check("acc_lane1_r1", 16'(r[15:8]), 16'd0);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;

    // Stream 6 beats with a 3-cycle consumer stall; r0 carries the beat index (10..15).
    mul_sel = 2'b10; add_sel = 2'b01; frac_c = 1'b0; acc_we = 1'b0; a = '0;
    sent = 0; got = 0; saw_stall = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      in_valid  = (sent < 6);
      c         = {8'h00, 8'(10 + sent)};
      out_ready = !(cyc >= 3 && cyc < 6);
      #1;
      acc_b  = in_valid && in_ready;
      take   = out_valid && out_ready;
      stall  = out_valid && !out_ready;
      prev_r = r;
      if (!in_ready) saw_stall = 1'b1;
      tick();
      if (acc_b) sent++;
      if (take) begin
        check($sformatf("stream_beat%0d", got), 16'(prev_r[7:0]), 16'(10 + got));
        got++;
      end
      if (stall) begin
        check($sformatf("stall_hold_r_c%0d", cyc), r, prev_r);
        check($sformatf("stall_hold_valid_c%0d", cyc), 16'(out_valid), 16'd1);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_got", 16'(got), 16'd6);
    check("stream_sent", 16'(sent), 16'd6);
    check("stream_in_ready_dropped", 16'(saw_stall), 16'd1);
    tick(); tick();
    check("stream_no_dup_valid", 16'(out_valid), 16'd0);
    check("stream_idle_busy", 16'(busy), 16'd0);

    // Reset with beats in flight: nothing emerges, accumulators reset.
    mul_sel = 2'b00; add_sel = 2'b00; frac_c = 1'b0; acc_we = 1'b1;
    a = 16'h0003; c = 16'h0003; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_rst_acc_r0", 16'(r[7:0]), 16'd9);
    tick();
    a = 16'h0005; c = 16'h0005; in_valid = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_mid_valid", 16'(out_valid), 16'd0);
    check("rst_mid_busy", 16'(busy), 16'd0);
    check("rst_mid_in_ready", 16'(in_ready), 16'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rst_flush_valid%0d", k), 16'(out_valid), 16'd0);
    end
    acc_we = 1'b0; a = 16'h0001; c = 16'h0001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("post_rst_valid", 16'(out_valid), 16'd1);
    check("post_rst_acc_r0", 16'(r[7:0]), 16'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/affine_mac_pipe.md
Name: affine_mac_pipe

Overview:
Parametrised, pipelined successor of the dual-lane affine multiply/add ALU. LANES signed W-bit lanes each compute r = sel(a)*c [frac-scaled] + sel(b-term). Per-lane accumulators are held internally, so the block is no longer fed by external acc inputs. Sits between the affine operand fetch and the result writeback, with a valid/ready handshake on both sides.

Parameters:
W, 8, lane data width (signed two's complement), >=4
LANES, 2, lane count; must be even (adder mode pairs lane i with lane i^1)
FRAC, 7, fractional bits used when frac_c=1; 1..W-1

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts beat this cycle
a  in  LANES*W  multiplicand per lane (lane i at [i*W +: W])
c  in  LANES*W  multiplier per lane
mul_sel  in  2  00: a; 01: 0; 1x: constant 1
add_sel  in  2  00: lane accumulator; 01: 0; 1x: partner lane product
frac_c  in  1  1: fixed-point Q(FRAC) product scaling; 0: integer
acc_we  in  1  write the lane result into the lane accumulator
acc_clr  in  1  clear all accumulators (no beat required)
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result
r  out  LANES*W  lane results
busy  out  1  any pipeline stage holds a beat

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: out_valid=0, r=0, busy=0, all accumulators=0, stage valids=0. in_ready=1 from the first cycle after reset. A reset mid-operation discards in-flight beats; no output is produced for them.
- Pipeline: S1 registers the 2W-bit products and the control (add_sel, acc_we). S2 registers the sums into r and sets out_valid. Latency: 2 cycles from the accepting edge to out_valid.
- Handshake: beat accepted when in_valid && in_ready. advance = !out_valid || out_ready. in_ready = !s1_valid || advance. S1 moves to S2 only on advance. While out_valid && !out_ready, r and out_valid are held stable. Full throughput (1 beat/cycle) when out_ready=1.
- Multiply: p = mul_a * c as full signed 2W bits. Scaled product ps = frac_c ? p[FRAC+W-1:FRAC] : p[W-1:0]. Truncation toward -inf, wrap, no rounding.
- Add (in S2): operand b = acc[i], 0, or ps of lane i^1. r[i] = ps[i] + b, W-bit wrap.
- Accumulator: if acc_we and the beat moves into S2, acc[i] <= r[i]. ACC mode reads the accumulator value as it stands in S2, so back-to-back ACC beats chain with no bubble.
- acc_clr: clears the accumulators at the next edge. If it coincides with an S2 write, the clear wins. acc_clr does not affect beats in flight except for the accumulator operand they read: a beat entering S2 on the same edge reads the pre-clear value.
- busy = s1_valid | out_valid.

Optional Feature:
Macro AFFINE_MAC_SAT_EN.
- Defined: ps saturates to [-2^(W-1), 2^(W-1)-1] when the discarded upper product bits are not a sign extension. The lane add also saturates instead of wrapping.
- Undefined: pure two's-complement wrap as described above.
- Latency and handshake are identical in both builds.

Test Plan:
- W=8, frac_c=1, mul_sel=00, add_sel=01, a0=c0=64 (0.5) -> r0=32 (0.25) exactly 2 cycles after acceptance.
- frac_c=0, acc_we=1, add_sel=00, three beats with a0=2, c0=3 -> r0=6, 12, 18 on consecutive cycles. Then acc_clr plus a beat with a0=1, c0=1 -> r0=1.
- Adder mode add_sel=1x, frac_c=0, a0=2, c0=3, a1=4, c1=5 -> r0=r1=26. mul_sel=1x with c0=7, add_sel=01 -> r0=7.
- Stream 6 beats, hold out_ready=0 for 3 cycles mid-stream -> in_ready drops once S1 and S2 are full, r holds, no beat lost or duplicated, order preserved.
- frac_c=0, a0=127, c0=2 -> r0=0xFE (-2); with AFFINE_MAC_SAT_EN defined -> r0=127. Likewise -128*2 -> 0x00, and -128 with SAT.
- Assert rst for 1 cycle with two beats in flight -> no out_valid for those beats, accumulators read 0 on the next ACC beat, in_ready=1 the cycle after reset.
